pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EXE, EXE/MEM regs).
//  Resolves exceptions, SRAM wait states, load-use hazards and the multi-cycle iterative
//  divider, which it sequences with an internal FSM/counter. Sits beside the datapath;
//  all outputs drive the stall/flush pins of the pipeline register banks and the divider.
// PARAMETERS
//  DIV_CYCLES  33  divider latency in cycles, start to result-valid; legal range 2..63
//  CNT_W       6   width of the divide cycle counter; must satisfy 2^CNT_W > DIV_CYCLES
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous reset, active-high
//  id_rs, id_rt   in   5   source register numbers of the instruction in ID
//  id_use_rs/rt   in   1   the ID instruction actually reads rs / rt
//  ex_load        in   1   EXE instruction is a load (load_type != 0)
//  ex_wreg        in   1   EXE instruction writes the RF
//  ex_waddr       in   5   EXE destination register number
//  ex_is_div      in   1   EXE instruction is DIV/DIVU
//  ex_is_sign_div in   1   signed divide (DIV)
//  if_stall       in   1   instruction SRAM not ready
//  mem_stall      in   1   data SRAM not ready
//  exc_flush      in   1   exception/ERET taken in MEM
//  pc_stall, if_id_stall, id_exe_stall, exe_mem_stall  out 1  hold the named register
//  if_id_flush, id_exe_flush, exe_mem_flush            out 1  bubble the named register
//  div_start      out  1   one-cycle pulse: divider latches operands
//  div_signed     out  1   signed mode; valid with div_start
//  div_done       out  1   divider result valid; EXE captures HI/LO
//  stall_cycles   out  32  count of cycles with pc_stall=1
// BEHAVIOUR
//  Reset (rst=1 at posedge): FSM->D_IDLE, cnt->0, stall_cycles->0. While rst=1 all
//   stall/flush/div_* outputs are 0.
//  Divide FSM (registered; cnt is CNT_W bits):
//   D_IDLE: ex_is_div & !exc_flush -> div_start=1, div_signed=ex_is_sign_div,
//           cnt<=DIV_CYCLES-2, -> D_RUN
//   D_RUN : cnt!=0 -> cnt<=cnt-1; cnt==0 -> D_DONE; exc_flush -> D_IDLE (abort, no done)
//   D_DONE: div_done=1; mem_stall=1 -> stay (div_done held, no relaunch);
//           otherwise -> D_IDLE (the divide leaves EXE this edge)
//   The div_start cycle is the first latency cycle: div_done is first high exactly
//    DIV_CYCLES cycles after the div_start cycle.
//  div_busy = ex_is_div & (state!=D_DONE)  [includes the D_IDLE launch cycle]
//  load_use = ex_load & ex_wreg & ex_waddr!=0 &
//             ((id_use_rs & id_rs==ex_waddr) | (id_use_rt & id_rt==ex_waddr))
//  Stall/flush outputs are combinational. Strict priority, first match wins:
//   1 exc_flush : if_id_flush=id_exe_flush=exe_mem_flush=1; all stalls 0
//   2 mem_stall : pc, if_id, id_exe, exe_mem stalls=1
//   3 div_busy  : pc, if_id, id_exe stalls=1; exe_mem_flush=1
//   4 load_use  : pc, if_id stalls=1; id_exe_flush=1
//   5 if_stall  : pc_stall=1; if_id_flush=1
//   Outputs not named in the matching case are 0.
//  stall_cycles: +1 on every cycle with pc_stall=1; wraps 0xFFFFFFFF->0.
//  Back-to-back divides: the 2nd launches from D_IDLE the cycle after D_DONE.
// TESTING
//  T1 rst held 3 cycles, then idle inputs -> all outputs 0, stall_cycles=0.
//  T2 ex_load=1, ex_wreg=1, ex_waddr=5, id_rs=5, id_use_rs=1 -> pc/if_id stall=1,
//     id_exe_flush=1; same with ex_waddr=0 -> no stall.
//  T3 DIV_CYCLES=33, ex_is_div held -> div_start at c0; stalls + exe_mem_flush c0..c32;
//     div_done=1 at c33 with stalls released; stall_cycles +33.
//  T4 exc_flush at c10 of a divide -> all three flushes=1; FSM D_IDLE next cycle;
//     div_done never asserted.
//  T5 mem_stall=1 in the D_DONE cycle for 2 cycles -> div_done held 3 cycles, all stalls
//     on, no second div_start.
//  T6 if_stall=1 together with load_use=1 -> load_use response only (priority 4 wins).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer and iterative-divider controller for the
//            5-stage pipeline (PC, IF/ID, ID/EXE, EXE/MEM register banks).
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_load,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_is_div,
    input  logic        ex_is_sign_div,
    input  logic        if_stall,
    input  logic        mem_stall,
    input  logic        exc_flush,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_exe_stall,
    output logic        exe_mem_stall,
    output logic        if_id_flush,
    output logic        id_exe_flush,
    output logic        exe_mem_flush,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_RUN  = 2'd1,
        D_DONE = 2'd2
    } div_state_e;

    // Launch cycle counts as the first latency cycle, hence the -2 preload.
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;

    logic w_div_start;
    logic w_div_done;
    logic w_div_busy;
    logic w_load_use;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_div_start = 1'b0;
        w_div_done  = 1'b0;
        case (state_q)
            D_IDLE: begin
                if (ex_is_div && !exc_flush) begin
                    w_div_start = 1'b1;
                    cnt_d       = C_CNT_LOAD;
                    state_d     = D_RUN;
                end
            end
            D_RUN: begin
                if (exc_flush) begin
                    state_d = D_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = D_DONE;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            D_DONE: begin
                w_div_done = 1'b1;
                if (!mem_stall) begin
                    state_d = D_IDLE;
                end
            end
            default: state_d = D_IDLE;
        endcase
    end

    assign w_div_busy = ex_is_div && (state_q != D_DONE);
    assign w_load_use = ex_load && ex_wreg && (ex_waddr != 5'd0) &&
                        ((id_use_rs && (id_rs == ex_waddr)) ||
                         (id_use_rt && (id_rt == ex_waddr)));

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_exe_stall  = 1'b0;
        exe_mem_stall = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        div_start     = 1'b0;
        div_signed    = 1'b0;
        div_done      = 1'b0;
        if (!rst) begin
            div_start  = w_div_start;
            div_signed = w_div_start && ex_is_sign_div;
            div_done   = w_div_done;
            if (exc_flush) begin
                if_id_flush   = 1'b1;
                id_exe_flush  = 1'b1;
                exe_mem_flush = 1'b1;
            end else if (mem_stall) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_exe_stall  = 1'b1;
                exe_mem_stall = 1'b1;
            end else if (w_div_busy) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_exe_stall  = 1'b1;
                exe_mem_flush = 1'b1;
            end else if (w_load_use) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_exe_flush  = 1'b1;
            end else if (if_stall) begin
                pc_stall      = 1'b1;
                if_id_flush   = 1'b1;
            end
        end
    end

    assign stall_cycles_d = stall_cycles_q + {31'd0, pc_stall};
    assign stall_cycles   = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= D_IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule
`default_nettype wire
